// File: rtl/word_count_pkg.sv
// Shared types and helpers for the word-count accumulator: entry layout, FSM states,
// and the saturating count adder.
package word_count_pkg;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned ACCUM_DIN_W = 64;

  typedef struct packed {
    logic [31:0]      value;
    logic [CNT_W-1:0] count;
  } wc_entry_t;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DRAIN, S_DUMP} state_e;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [31:0]      b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/wc_entry_ram.sv
// Simple dual-port entry RAM: one write port, one read-first read port, 1-cycle read latency.
module wc_entry_ram
  import word_count_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  wc_entry_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output wc_entry_t         rdata
);

  wc_entry_t mem [2**ADDR_W];

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/word_count_accum.sv
// Accumulate-write sink: per-entry {key, count} RAM updated by a 2-stage read-modify-write
// pipeline, with auto-clear and a valid/ready dump port backed by a 2-entry skid buffer.
module word_count_accum
  import word_count_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            accum_addr,
  input  logic [ACCUM_DIN_W-1:0] accum_din,
  input  logic                   accum_we,
  input  logic                   clear_kick,
  input  logic                   dump_kick,
  input  logic [ADDR_W:0]        dump_num,
  output logic                   ready,
  output logic                   busy,
  output logic [63:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [15:0]            drop_count,
  output logic                   addr_err
);

  localparam int unsigned     DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W + 1)'(1);

  state_e                   state_q;
  logic [ADDR_W-1:0]        clr_addr_q;
  logic                     drain_cnt_q, drain_to_clear_q;
  logic [ADDR_W:0]          num_q, rd_idx_q;
  logic                     pend_q, pend_last_q;
  logic [63:0]              fifo_data_q [2];
  logic [1:0]               fifo_last_q;
  logic                     fifo_wr_q, fifo_rd_q;
  logic [1:0]               fifo_cnt_q;

  logic                     s1_valid_q;
  logic [ADDR_W-1:0]        s1_addr_q;
  logic [ACCUM_DIN_W-1:0]   s1_din_q;
  logic                     w1_valid_q, w2_valid_q;
  logic [ADDR_W-1:0]        w1_addr_q, w2_addr_q;
  wc_entry_t                w1_data_q, w2_data_q;
  logic [15:0]              drop_q;
  logic                     addr_err_q;

  wc_entry_t                ram_rdata, ram_wdata, fwd_old, s2_data;
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_waddr, ram_raddr;
  logic                     addr_bad, accept, pop, issue;
  logic [2:0]               occ;

  assign addr_bad   = |accum_addr[31:ADDR_W];
  assign accept     = accum_we && (state_q == S_IDLE) && !addr_bad;
  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (fifo_cnt_q != 2'd0);
  assign out_data   = fifo_data_q[fifo_rd_q];
  assign out_last   = out_valid && fifo_last_q[fifo_rd_q];
  assign drop_count = drop_q;
  assign addr_err   = addr_err_q;
  assign pop        = out_valid && out_ready;
  // Skid buffer plus in-flight read must never exceed two entries.
  assign occ        = 3'(fifo_cnt_q) + 3'(pend_q) - 3'(pop);
  assign issue      = (state_q == S_DUMP) && (rd_idx_q < num_q) && (occ < 3'd2);

  // Newest in-flight result wins over older ones and over the RAM word.
  always_comb begin
    fwd_old = ram_rdata;
    if (w2_valid_q && (w2_addr_q == s1_addr_q)) fwd_old = w2_data_q;
    if (w1_valid_q && (w1_addr_q == s1_addr_q)) fwd_old = w1_data_q;
    s2_data.value = s1_din_q[63:32];
    s2_data.count = sat_add(fwd_old.count, s1_din_q[31:0]);
  end

  always_comb begin
    ram_we    = (state_q == S_CLEAR) || s1_valid_q;
    ram_waddr = (state_q == S_CLEAR) ? clr_addr_q : s1_addr_q;
    ram_wdata = (state_q == S_CLEAR) ? '0 : s2_data;
    ram_raddr = (state_q == S_DUMP) ? rd_idx_q[ADDR_W-1:0] : accum_addr[ADDR_W-1:0];
  end

  wc_entry_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_din_q   <= '0;
      w1_valid_q <= 1'b0;
      w1_addr_q  <= '0;
      w1_data_q  <= '0;
      w2_valid_q <= 1'b0;
      w2_addr_q  <= '0;
      w2_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_addr_q  <= accum_addr[ADDR_W-1:0];
      s1_din_q   <= accum_din;
      w1_valid_q <= s1_valid_q;
      w1_addr_q  <= s1_addr_q;
      w1_data_q  <= s2_data;
      w2_valid_q <= w1_valid_q;
      w2_addr_q  <= w1_addr_q;
      w2_data_q  <= w1_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (accum_we && ((state_q != S_IDLE) || addr_bad) && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (accum_we && addr_bad) addr_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_CLEAR;
      clr_addr_q       <= '0;
      drain_cnt_q      <= 1'b0;
      drain_to_clear_q <= 1'b0;
      num_q            <= '0;
      rd_idx_q         <= '0;
      pend_q           <= 1'b0;
      pend_last_q      <= 1'b0;
      fifo_data_q[0]   <= '0;
      fifo_data_q[1]   <= '0;
      fifo_last_q      <= '0;
      fifo_wr_q        <= 1'b0;
      fifo_rd_q        <= 1'b0;
      fifo_cnt_q       <= '0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue && (rd_idx_q == num_q - ONE_N);
      if (pend_q) begin
        fifo_data_q[fifo_wr_q] <= ram_rdata;
        fifo_last_q[fifo_wr_q] <= pend_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(pend_q) - 2'(pop);

      unique case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          if (&clr_addr_q) state_q <= S_IDLE;
        end
        S_IDLE: begin
          drain_cnt_q <= 1'b0;
          if (clear_kick) begin
            state_q          <= S_DRAIN;
            drain_to_clear_q <= 1'b1;
          end else if (dump_kick && (dump_num != '0)) begin
            state_q          <= S_DRAIN;
            drain_to_clear_q <= 1'b0;
            num_q            <= (dump_num > DEPTH_N) ? DEPTH_N : dump_num;
            rd_idx_q         <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt_q <= 1'b1;
          clr_addr_q  <= '0;
          if (drain_cnt_q) state_q <= drain_to_clear_q ? S_CLEAR : S_DUMP;
        end
        S_DUMP: begin
          if (issue) rd_idx_q <= rd_idx_q + ONE_N;
          if (pop && out_last) state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/word_count_accum.md
Name: word_count_accum

Overview:
- Receiving end of the accumulate-write stream (accum_addr/accum_din/accum_we) produced by the search-and-add engine.
- Holds one {key_value, count} entry per Axonerve entry address in on-chip RAM, and adds each increment with a read-modify-write pipeline.
- On request, streams entries 0..dump_num-1 out over a valid/ready interface for host readback.
- Auto-clears the RAM after reset and on request.

Parameters:
- ADDR_W, 10: entry index width; DEPTH = 2**ADDR_W entries.
- CNT_W, 32: count field width. accum_din[31:0] is the increment; accum_din[63:32] is the key value.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- accum_addr  in  32  entry address; bits [ADDR_W-1:0] index the RAM.
- accum_din  in  64  {key_value[31:0], increment[31:0]}.
- accum_we  in  1  one write per asserted cycle; there is no backpressure.
- clear_kick  in  1  start a clear of all entries.
- dump_kick  in  1  start a dump.
- dump_num  in  ADDR_W+1  number of entries to dump.
- ready  out  1  high in IDLE only.
- busy  out  1  high in CLEAR, DRAIN and DUMP.
- out_data  out  64  {key_value, count}.
- out_valid  out  1  output data valid.
- out_ready  in  1  downstream accepts data.
- out_last  out  1  marks the final dumped entry.
- drop_count  out  16  saturating count of discarded writes.
- addr_err  out  1  sticky; set when accum_addr[31:ADDR_W] != 0.

Behaviour:
- Reset values: ready=0, busy=1, out_valid=0, out_last=0, out_data=0, drop_count=0, addr_err=0. The FSM enters CLEAR. RAM contents are not reset.
- States:
  - CLEAR: writes zeros to entries 0..DEPTH-1, one per cycle (DEPTH cycles), then goes to IDLE.
  - IDLE: ready=1, busy=0. Accumulates writes.
    - clear_kick goes to DRAIN, then CLEAR.
    - dump_kick goes to DRAIN, then DUMP.
    - If both kicks are high in the same cycle, clear wins.
  - DRAIN: 2 cycles, letting in-flight RMW writes retire.
  - DUMP: described below; returns to IDLE after the out_last beat is accepted.
- Accumulate pipeline (IDLE only):
  - Cycle T: sample the write and issue the RAM read.
  - Cycle T+1: count_new = sat(count_old + increment); value_new = key_value. Both are written at the end of T+1.
  - A read at T+2 or later observes the write.
- Hazards:
  - Back-to-back or alternating writes to the same address must accumulate exactly.
  - The stage-2 result is forwarded for a match with the immediately preceding write and the one before it; the newest match wins.
  - A RAM write-after-read collision in the same cycle uses the forwarded value.
- Saturation: count saturates at 2**CNT_W-1 and never wraps.
- Drops: an accum_we in CLEAR, DRAIN or DUMP is discarded and increments drop_count (saturating at 0xFFFF).
- Address errors: if accum_addr[31:ADDR_W] != 0, the write is discarded, addr_err is set, and drop_count increments.
- DUMP:
  - dump_num is latched at dump_kick. dump_num=0 returns directly to IDLE with no beats. Values above DEPTH clamp to DEPTH.
  - Entries are read sequentially, with a 2-entry skid buffer so out_valid can stay high across stalls.
  - out_data and out_valid hold until out_ready; the beat transfers when out_valid && out_ready.
  - out_last=1 on beat dump_num-1 only.
- Kick handling: kicks are ignored outside IDLE. dump_kick does not clear entries.
- Reset mid-operation: reset asynchronously aborts any state, drops out_valid, and restarts CLEAR.

Decomposition:
- Package word_count_pkg holds:
  - typedef struct packed {logic [31:0] value; logic [CNT_W-1:0] count;} wc_entry_t;
  - ACCUM_DIN_W=64;
  - state enum {S_CLEAR, S_IDLE, S_DRAIN, S_DUMP}.
- Sub-module wc_entry_ram: simple dual-port RAM, 1 write port and 1 read port, read-first, 1-cycle synchronous read, DEPTH x 64.

Test Plan:
- Reset, then wait: busy high for DEPTH cycles (1024 at default), then ready=1. Dump 4 entries with out_ready=1 → 4 beats of 64'h0, out_last on beat 4.
- Writes to addr 5 on 3 consecutive cycles, din={32'hABCD,32'h1} → dump entry 5 returns {32'hABCD, 32'd3}, with drop_count=0.
- Alternating writes to addr 2, 3, 2, 3, 2, each with increment 1 → entry 2 count=3 and entry 3 count=2 (forwarding check).
- Preload addr 7 to count 32'hFFFFFFFE, then add 5 → count=32'hFFFFFFFF.
- Dump dump_num=8 with out_ready toggling 1,0,0,1 → 8 beats in order, data stable while stalled, exactly one out_last.
- Write to addr 32'h0001_0000, then a write during DUMP → addr_err=1, drop_count=2, RAM unchanged. Assert reset mid-DUMP → out_valid=0 immediately, then CLEAR, then all entries read 0.
